// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipe.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: field-width select encodings, FSM state enum, sel -> width helper.
package imm_ext_pkg;

  // Field-width select encodings carried on the sel input.
  localparam logic [1:0] SEL_W3   = 2'b00;
  localparam logic [1:0] SEL_W5   = 2'b01;
  localparam logic [1:0] SEL_W8   = 2'b10;
  localparam logic [1:0] SEL_WMAX = 2'b11;

  // Long-immediate tracking: HELD means an upper half is waiting for its suffix.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } imm_state_t;

  // Number of significant field bits for a normal beat.
  function automatic int unsigned sel_width(input logic [1:0] s, input int unsigned wmax);
    int unsigned w;
    w = wmax;
    case (s)
      SEL_W3:   w = 3;
      SEL_W5:   w = 5;
      SEL_W8:   w = 8;
      default:  w = wmax;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extend-and-shift of a value whose significant width is chosen at run time.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns all flow control.
// Ports: val/w   - raw value and number of significant LSBs (bits above w ignored)
//        is_signed - sign-extend from bit w-1 when set, else zero-extend
//        shift   - left shift 0..3 applied after extension, truncated to XLEN
//        imm     - XLEN-wide result
module imm_ext_core #(
  parameter int XLEN = 32,
  parameter int VW   = 22,
  parameter int W_W  = $clog2(VW + 1)
) (
  input  logic [VW-1:0]   val,
  input  logic [W_W-1:0]  w,
  input  logic            is_signed,
  input  logic [1:0]      shift,
  output logic [XLEN-1:0] imm
);

  localparam int IW = $clog2(VW);

  logic [XLEN-1:0] val_x;
  logic [XLEN-1:0] hi_mask;
  logic [IW-1:0]   msb_idx;
  logic            sbit;
  logic [XLEN-1:0] ext;

  always_comb begin
    val_x   = XLEN'(val);
    // Ones in every bit position at or above w: these get replaced by the fill bit.
    hi_mask = {XLEN{1'b1}} << w;
    msb_idx = IW'(w - W_W'(1));
    sbit    = is_signed && val[msb_idx];
    ext     = (val_x & ~hi_mask) | (sbit ? hi_mask : '0);
    imm     = ext << shift;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extension: one field per beat, optional prefix/suffix long-immediate merge.
// Latency: 1 cycle from accepted normal/suffix beat to registered out_valid/imm_out.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); a stalled output holds imm_out and prefix state.
// Ports: clk, rst_n (async active-low), flush (sync discard of held prefix and output),
//        in_valid/in_ready/imm_in/sel/is_signed/shift/prefix (input beat),
//        out_valid/out_ready/imm_out (output beat), prefix_ovr (pulse: held prefix replaced).
// Build option: define IMM_EXT_PREFIX_EN to enable prefix/suffix merging; otherwise prefix is ignored.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IN_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] imm_in,
  input  logic [1:0]      sel,
  input  logic            is_signed,
  input  logic [1:0]      shift,
  input  logic            prefix,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            prefix_ovr
);

  localparam int VW  = 2 * IN_W;
  localparam int W_W = $clog2(VW + 1);

  logic            accept;
  logic            load_out;
  logic [VW-1:0]   core_val;
  logic [W_W-1:0]  core_w;
  logic [XLEN-1:0] core_imm;
  logic [W_W-1:0]  norm_w;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign norm_w   = W_W'(sel_width(sel, IN_W));

`ifdef IMM_EXT_PREFIX_EN

  imm_state_t      state_q, state_nxt;
  logic [IN_W-1:0] pfx_q;
  logic            ovr_q;
  logic            is_suffix;

  assign is_suffix = (state_q == ST_HELD) && !prefix;
  assign load_out  = accept && !prefix;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (accept && prefix)  state_nxt = ST_HELD;
      ST_HELD: if (accept && !prefix) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pfx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ovr_q   <= accept && prefix && (state_q == ST_HELD);
      if (flush) begin
        pfx_q <= '0;
      end else if (accept && prefix) begin
        pfx_q <= imm_in;
      end
    end
  end

  // A suffix ignores sel: the merged value always spans both halves.
  always_comb begin
    core_val = VW'(imm_in);
    core_w   = norm_w;
    if (is_suffix) begin
      core_val = {pfx_q, imm_in};
      core_w   = W_W'(VW);
    end
  end

  assign prefix_ovr = ovr_q;

`else

  logic unused_prefix;
  assign unused_prefix = prefix;

  assign load_out   = accept;
  assign core_val   = VW'(imm_in);
  assign core_w     = norm_w;
  assign prefix_ovr = 1'b0;

`endif

  imm_ext_core #(
    .XLEN (XLEN),
    .VW   (VW),
    .W_W  (W_W)
  ) u_core (
    .val       (core_val),
    .w         (core_w),
    .is_signed (is_signed),
    .shift     (shift),
    .imm       (core_imm)
  );

  // Output register refills on the same edge it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      imm_out   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      imm_out   <= core_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed cases plus randomized traffic vs. a transaction-level model.
// Latency: n/a.
// Backpressure: out_ready is driven randomly and in bursts of stall.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] imm_in = '0;
  logic [1:0]  sel = 2'b00;
  logic        sgn = 1'b0;
  logic [1:0]  shift = 2'b00;
  logic        prefix = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imm_out;
  logic        prefix_ovr;

  int n_chk = 0;
  int n_err = 0;

  // Reference state, tracked per transaction rather than per register.
  bit          m_vld;
  logic [31:0] m_out;
  bit          m_held;
  int          m_pfx;
  bit          m_ovr;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .IN_W(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_in     (imm_in),
    .sel        (sel),
    .is_signed  (sgn),
    .shift      (shift),
    .prefix     (prefix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .imm_out    (imm_out),
    .prefix_ovr (prefix_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Take the low w bits, interpret as signed or unsigned, multiply by 2^sh, keep 32 bits.
  function automatic logic [31:0] ref_imm(input longint raw, input int w, input bit s, input int sh);
    longint v;
    logic [63:0] r;
    v = raw % (longint'(1) << w);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    v = v * (longint'(1) << sh);
    r = v;
    return r[31:0];
  endfunction

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3;
      2'b01:   return 5;
      2'b10:   return 8;
      default: return 11;
    endcase
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_out  = '0;
    m_held = 0;
    m_pfx  = 0;
    m_ovr  = 0;
  endtask

  // One clock: check in_ready for the current inputs, advance model, check registered outputs.
  task automatic tick();
    bit          rdy, acc, n_vld, n_held, n_ovr;
    logic [31:0] n_out;
    int          n_pfx;
    #1;
    rdy = !flush && (!m_vld || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc    = in_valid && rdy;
    n_vld  = m_vld && !out_ready;
    n_out  = m_out;
    n_held = m_held;
    n_pfx  = m_pfx;
    n_ovr  = 0;
    if (flush) begin
      n_vld  = 0;
      n_held = 0;
    end else if (acc) begin
`ifdef IMM_EXT_PREFIX_EN
      if (prefix) begin
        n_ovr  = m_held;
        n_held = 1;
        n_pfx  = int'(imm_in);
      end else if (m_held) begin
        n_out  = ref_imm(longint'(m_pfx) * 2048 + longint'(imm_in), 22, sgn, int'(shift));
        n_vld  = 1;
        n_held = 0;
      end else begin
        n_out = ref_imm(longint'(imm_in), width_of(sel), sgn, int'(shift));
        n_vld = 1;
      end
`else
      n_out = ref_imm(longint'(imm_in), width_of(sel), sgn, int'(shift));
      n_vld = 1;
`endif
    end
    @(posedge clk);
    #1;
    m_vld  = n_vld;
    m_out  = n_out;
    m_held = n_held;
    m_pfx  = n_pfx;
    m_ovr  = n_ovr;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
    chk("imm_out", imm_out, m_out);
    chk("prefix_ovr", {31'b0, prefix_ovr}, {31'b0, m_ovr});
  endtask

  task automatic beat(input logic [10:0] v, input logic [1:0] s, input bit sg,
                      input logic [1:0] sh, input bit p);
    in_valid = 1'b1;
    imm_in   = v;
    sel      = s;
    sgn      = sg;
    shift    = sh;
    prefix   = p;
    tick();
    in_valid = 1'b0;
    prefix   = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_imm_out", imm_out, 32'd0);
    chk("rst_prefix_ovr", {31'b0, prefix_ovr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Field widths and extension modes.
    beat(11'h005, 2'b00, 1'b0, 2'd0, 1'b0);
    chk("w3_zero", imm_out, 32'h0000_0005);
    beat(11'h005, 2'b00, 1'b1, 2'd0, 1'b0);
    chk("w3_sign", imm_out, 32'hFFFF_FFFD);
    beat(11'h0AA, 2'b10, 1'b1, 2'd2, 1'b0);
    chk("w8_sign_sh2", imm_out, 32'hFFFF_FEA8);
    beat(11'h7F5, 2'b01, 1'b0, 2'd0, 1'b0);
    chk("w5_zero_upper_ignored", imm_out, 32'h0000_0015);
    tick();

    // Long immediate merge, prefix overwrite.
    beat(11'h555, 2'b00, 1'b0, 2'd0, 1'b1);
    beat(11'h555, 2'b00, 1'b1, 2'd1, 1'b0);
`ifdef IMM_EXT_PREFIX_EN
    chk("long_imm", imm_out, 32'hFFD5_5AAA);
`endif
    tick();
    beat(11'h7FF, 2'b00, 1'b0, 2'd0, 1'b1);
    beat(11'h000, 2'b00, 1'b0, 2'd0, 1'b1);
    beat(11'h001, 2'b00, 1'b1, 2'd0, 1'b0);
    chk("ovr_suffix", imm_out, 32'h0000_0001);

    // Backpressure: three stalled cycles with a beat offered, then release.
    out_ready = 1'b0;
    beat(11'h3C3, 2'b11, 1'b1, 2'd1, 1'b0);
    in_valid = 1'b1;
    imm_in   = 11'h012;
    sel      = 2'b10;
    sgn      = 1'b0;
    shift    = 2'd0;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("after_stall", imm_out, 32'h0000_0012);

    // Flush discards a held prefix and the beat offered alongside it.
    beat(11'h555, 2'b00, 1'b0, 2'd0, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    beat(11'h001, 2'b11, 1'b0, 2'd0, 1'b0);
    chk("flush_drop_prefix", imm_out, 32'h0000_0001);

    // Asynchronous reset while a prefix is held.
    beat(11'h2AA, 2'b00, 1'b0, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_imm_out", imm_out, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(11'h00F, 2'b01, 1'b1, 2'd0, 1'b0);
    chk("post_reset_idle", imm_out, 32'h0000_000F);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      imm_in    = 11'($urandom_range(0, 2047));
      sel       = 2'($urandom_range(0, 3));
      sgn       = 1'($urandom_range(0, 1));
      shift     = 2'($urandom_range(0, 3));
      prefix    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
